// File: rtl/kmp_string_matcher.sv
// kmp_string_matcher: streams bytes against a registered pattern and KMP failure table, reporting every match.
module kmp_string_matcher #(
   parameter int BYTE        = 8,
   parameter int MAX_PATTERN = 8,
   parameter int MAX_PAT_ADD = 4,
   parameter int STR_ADD     = 16
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           i_valid,
   input  logic [MAX_PATTERN*BYTE-1:0]    pattern,
   input  logic [MAX_PAT_ADD*MAX_PATTERN-1:0] fail_func,
   input  logic [MAX_PAT_ADD-1:0]         pat_len,
   input  logic                           s_valid,
   input  logic [BYTE-1:0]                s_data,
   input  logic                           s_last,
   output logic                           s_ready,
   output logic                           o_match_valid,
   output logic [STR_ADD-1:0]             o_match_pos,
   output logic                           o_done,
   output logic [STR_ADD-1:0]             o_match_cnt,
   output logic                           o_err
);
   localparam int PI = (MAX_PATTERN > 1) ? $clog2(MAX_PATTERN) : 1;

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

   state_t                                 state_q, state_d;
   logic [MAX_PATTERN-1:0][BYTE-1:0]       pat_q;
   logic [MAX_PATTERN-1:0][MAX_PAT_ADD-1:0] ff_q;
   logic [MAX_PAT_ADD-1:0]                 len_q, q_q, q_d;
   logic [STR_ADD-1:0]                     pos_q, pos_d, cnt_q, cnt_d, mpos_q, mpos_d;
   logic                                   mv_q, mv_d, err_q, err_d;
   logic                                   hit, full, bad;
   logic [PI-1:0]                          qi, qm1, lm1;

   always_comb begin
      qi      = PI'(q_q);
      qm1     = PI'(q_q - 1'b1);
      lm1     = PI'(len_q - 1'b1);
      hit     = pat_q[qi] == s_data;
      full    = (q_q + 1'b1) == len_q;
      bad     = (pat_len == '0) || (pat_len > MAX_PAT_ADD'(MAX_PATTERN));
      s_ready = (state_q == SCAN) && s_valid && (hit || q_q == '0);
      state_d = state_q;
      q_d     = q_q;
      pos_d   = pos_q;
      cnt_d   = cnt_q;
      mv_d    = 1'b0;
      mpos_d  = mpos_q;
      err_d   = err_q;
      case (state_q)
         IDLE: if (i_valid) begin
            state_d = bad ? DONE : SCAN;
            err_d   = bad;
            q_d     = '0;
            pos_d   = '0;
            cnt_d   = '0;
         end
         SCAN: if (s_ready) begin
            pos_d = pos_q + 1'b1;
            if (hit) begin
               // After a full match, resume from the longest border so overlaps are found
               q_d = full ? ff_q[lm1] : q_q + 1'b1;
               if (full) begin
                  mv_d   = 1'b1;
                  mpos_d = pos_q - STR_ADD'(len_q) + 1'b1;
                  cnt_d  = &cnt_q ? cnt_q : cnt_q + 1'b1;
               end
            end
            if (s_last) state_d = DONE;
         end else if (s_valid) begin
            q_d = ff_q[qm1];
         end
         DONE: if (!i_valid) begin
            state_d = IDLE;
            err_d   = 1'b0;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         q_q     <= '0;
         pos_q   <= '0;
         cnt_q   <= '0;
         mv_q    <= 1'b0;
         mpos_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         q_q     <= q_d;
         pos_q   <= pos_d;
         cnt_q   <= cnt_d;
         mv_q    <= mv_d;
         mpos_q  <= mpos_d;
         err_q   <= err_d;
      end
   end

   always_ff @(posedge clk) begin
      if (state_q == IDLE && i_valid && !bad) begin
         pat_q <= pattern;
         ff_q  <= fail_func;
         len_q <= pat_len;
      end
   end

   assign o_match_valid = mv_q;
   assign o_match_pos   = mpos_q;
   assign o_done        = state_q == DONE;
   assign o_match_cnt   = cnt_q;
   assign o_err         = err_q;
endmodule

// File: tb/tb_kmp_string_matcher.sv
// tb_kmp_string_matcher: directed checks of the KMP matcher with hand-computed match positions and counts.
module tb_kmp_string_matcher;
   logic        clk = 1'b0;
   logic        reset, i_valid, s_valid, s_last;
   logic [63:0] pattern;
   logic [31:0] fail_func;
   logic [3:0]  pat_len;
   logic [7:0]  s_data;
   logic        s_ready, o_match_valid, o_done, o_err;
   logic [15:0] o_match_pos, o_match_cnt;

   int checks = 0, failures = 0, cyc = 0, stalls = 0;
   int mpos_q[$];
   int mcyc_q[$];
   bit gaps = 0;

   kmp_string_matcher dut (
      .clk(clk), .reset(reset), .i_valid(i_valid), .pattern(pattern), .fail_func(fail_func),
      .pat_len(pat_len), .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
      .o_match_valid(o_match_valid), .o_match_pos(o_match_pos), .o_done(o_done),
      .o_match_cnt(o_match_cnt), .o_err(o_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (o_match_valid === 1'b1) begin
         mpos_q.push_back(int'(o_match_pos));
         mcyc_q.push_back(cyc);
      end
      if (s_valid && s_ready !== 1'b1) stalls <= stalls + 1;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [7:0] b, input logic last);
      int n = 0;
      bit ok = 0;
      if (gaps) repeat ($urandom_range(0, 2)) begin
         @(posedge clk);
         #1;
      end
      s_valid = 1'b1;
      s_data  = b;
      s_last  = last;
      while (!ok && n < 20) begin
         @(negedge clk);
         if (s_ready === 1'b1) ok = 1;
         else n++;
      end
      check("handshake", 32'(ok), 32'd1);
      @(posedge clk);
      #1;
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) send(s[i], i == s.len() - 1);
   endtask

   task automatic load(input string p, input logic [31:0] f, input logic [3:0] l);
      pattern = '0;
      for (int k = 0; k < p.len(); k++) pattern[k*8 +: 8] = p[k];
      fail_func = f;
      pat_len   = l;
      i_valid   = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic unload();
      i_valid = 1'b0;
      @(posedge clk);
      #1;
      check("done_clear", 32'(o_done), 32'd0);
      check("err_clear", 32'(o_err), 32'd0);
   endtask

   task automatic run_abab(input string tag);
      int b  = mpos_q.size();
      int st = stalls;
      load("ABAB", 32'h2100, 4'd4);
      check({tag, "_not_done"}, 32'(o_done), 32'd0);
      send_str("ABABAB");
      check({tag, "_done"}, 32'(o_done), 32'd1);
      check({tag, "_last_pulse"}, 32'(o_match_valid), 32'd1);
      check({tag, "_last_pos"}, 32'(o_match_pos), 32'd2);
      check({tag, "_cnt"}, 32'(o_match_cnt), 32'd2);
      @(posedge clk);
      #1;
      check({tag, "_pulse_end"}, 32'(o_match_valid), 32'd0);
      check({tag, "_done_held"}, 32'(o_done), 32'd1);
      check({tag, "_nmatch"}, 32'(mpos_q.size() - b), 32'd2);
      check({tag, "_pos0"}, 32'(mpos_q[b]), 32'd0);
      check({tag, "_pos1"}, 32'(mpos_q[b+1]), 32'd2);
      check({tag, "_stalls"}, 32'(stalls - st), 32'd0);
      s_valid = 1'b1;
      s_data  = "A";
      #1;
      check({tag, "_ready_in_done"}, 32'(s_ready), 32'd0);
      s_valid = 1'b0;
      unload();
   endtask

   initial begin
      int b, st;
      reset = 1'b1; i_valid = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = '0;
      pattern = '0; fail_func = '0; pat_len = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_ready", 32'(s_ready), 32'd0);
      check("rst_mv", 32'(o_match_valid), 32'd0);
      check("rst_pos", 32'(o_match_pos), 32'd0);
      check("rst_done", 32'(o_done), 32'd0);
      check("rst_cnt", 32'(o_match_cnt), 32'd0);
      check("rst_err", 32'(o_err), 32'd0);
      reset = 1'b0;

      run_abab("abab");

      b = mpos_q.size();
      load("AB", 32'h0, 4'd2);
      send_str("XYZ");
      check("nomatch_done", 32'(o_done), 32'd1);
      check("nomatch_cnt", 32'(o_match_cnt), 32'd0);
      @(posedge clk);
      #1;
      check("nomatch_n", 32'(mpos_q.size() - b), 32'd0);
      unload();

      b = mpos_q.size();
      st = stalls;
      load("AAB", 32'h010, 4'd3);
      send_str("AAAB");
      check("aab_cnt", 32'(o_match_cnt), 32'd1);
      @(posedge clk);
      #1;
      check("aab_n", 32'(mpos_q.size() - b), 32'd1);
      check("aab_pos", 32'(mpos_q[b]), 32'd1);
      check("aab_stalls", 32'(stalls - st), 32'd1);
      unload();

      b = mpos_q.size();
      load("A", 32'h0, 4'd1);
      send_str("AAA");
      check("a_cnt", 32'(o_match_cnt), 32'd3);
      @(posedge clk);
      #1;
      check("a_n", 32'(mpos_q.size() - b), 32'd3);
      check("a_pos0", 32'(mpos_q[b]), 32'd0);
      check("a_pos1", 32'(mpos_q[b+1]), 32'd1);
      check("a_pos2", 32'(mpos_q[b+2]), 32'd2);
      check("a_gap01", 32'(mcyc_q[b+1] - mcyc_q[b]), 32'd1);
      check("a_gap12", 32'(mcyc_q[b+2] - mcyc_q[b+1]), 32'd1);
      unload();

      load("AB", 32'h0, 4'd0);
      check("len0_done", 32'(o_done), 32'd1);
      check("len0_err", 32'(o_err), 32'd1);
      check("len0_cnt", 32'(o_match_cnt), 32'd0);
      s_valid = 1'b1;
      s_data  = "A";
      #1;
      check("len0_ready", 32'(s_ready), 32'd0);
      s_valid = 1'b0;
      unload();
      load("AB", 32'h0, 4'd9);
      check("len9_done", 32'(o_done), 32'd1);
      check("len9_err", 32'(o_err), 32'd1);
      unload();

      load("ABAB", 32'h2100, 4'd4);
      send("A", 1'b0);
      send("B", 1'b0);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check("mid_rst_mv", 32'(o_match_valid), 32'd0);
      check("mid_rst_pos", 32'(o_match_pos), 32'd0);
      check("mid_rst_done", 32'(o_done), 32'd0);
      check("mid_rst_cnt", 32'(o_match_cnt), 32'd0);
      check("mid_rst_err", 32'(o_err), 32'd0);
      reset = 1'b0;
      run_abab("rerun");
      gaps = 1;
      run_abab("gaps");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
